mem_responder: RTL and testbench

Multi-cycle data-memory responder that sits on the memory side of the CPU load/store port. It serves one request at a time using a valid/ready handshake, with a configurable number of wait states. It performs little-endian byte, halfword and word accesses with sign or zero extension on loads. It also maps one word address to the external `ioin` input and an `ioout` output register. It is the target the pipelined core stalls against once its single-cycle `datamem` is replaced.

---
 rtl/mem_responder_pkg.sv | 57 +++++
 rtl/mem_responder_mem_array.sv | 27 ++
 rtl/mem_responder.sv | 142 ++++++++++++++
 tb/tb_mem_responder.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and lane helpers for the memory responder: funct3 widths,
// FSM states, load extension and store byte-enable generation.
package mem_pkg;

    typedef enum logic [2:0] {
        W_B  = 3'b000,
        W_H  = 3'b001,
        W_W  = 3'b010,
        W_BU = 3'b100,
        W_HU = 3'b101
    } width_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    // Shift the addressed lane down to bit 0, then extend to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  byte_off,
                                                input logic [2:0]  width);
        logic [31:0] s;
        s = word >> {byte_off, 3'b000};
        case (width)
            W_B:     load_extend = {{24{s[7]}}, s[7:0]};
            W_H:     load_extend = {{16{s[15]}}, s[15:0]};
            W_W:     load_extend = s;
            W_BU:    load_extend = {24'd0, s[7:0]};
            W_HU:    load_extend = {16'd0, s[15:0]};
            default: load_extend = 32'd0;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] byte_off,
                                            input logic [2:0] width);
        case (width)
            W_B:     store_be = 4'b0001 << byte_off;
            W_H:     store_be = 4'b0011 << byte_off;
            W_W:     store_be = 4'b1111;
            default: store_be = 4'b0000;
        endcase
    endfunction

    function automatic logic req_error(input logic [1:0] byte_off,
                                       input logic [2:0] width,
                                       input logic       we);
        case (width)
            W_B:        req_error = 1'b0;
            W_H:        req_error = byte_off[0];
            W_W:        req_error = |byte_off;
            W_BU, W_HU: req_error = we;
            default:    req_error = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// Byte-addressed storage organised as 32-bit words: synchronous byte-enable
// write, combinational word read. Contents are never reset.
module mem_array #(
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [3:0]            i_be,
    input  logic [ADDR_WIDTH-3:0] i_word_addr,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);
    localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_be[i]) r_mem[i_word_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_word_addr];

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle data-memory responder: one request at a time over valid/ready,
// configurable wait states, sign/zero-extending loads and one memory-mapped IO word.
module mem_responder
    import mem_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 17,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] IO_ADDR     = 32'h0001_FFFC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_we,
    input  logic [2:0]  req_width,
    input  logic [31:0] ioin,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] ioout,
    output state_t      o_dbg_state
);
    // Handshake: a request transfers on an edge where req_valid && req_ready;
    // a response transfers on an edge where resp_valid && resp_ready.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam logic       NO_WAIT   = (WAIT_CYCLES == 0);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr, r_wdata, r_rdata, r_ioout;
    logic        r_we, r_err, r_req_ready, r_resp_valid;
    logic [2:0]  r_width;

    logic        w_idle, w_req_err, w_commit, w_io_hit, w_we, w_mem_we;
    logic [31:0] w_addr, w_wdata, w_lanes, w_mem_rdata, w_load_word;
    logic [2:0]  w_width;
    logic [1:0]  w_off;
    logic [3:0]  w_be;

    // With no wait states the commit happens on the accept edge, so the
    // datapath uses the live request rather than the latched copy.
    assign w_idle      = (r_state == IDLE);
    assign w_addr      = w_idle ? req_addr  : r_addr;
    assign w_wdata     = w_idle ? req_wdata : r_wdata;
    assign w_we        = w_idle ? req_we    : r_we;
    assign w_width     = w_idle ? req_width : r_width;
    assign w_off       = w_addr[1:0];
    assign w_req_err   = req_error(req_addr[1:0], req_width, req_we);
    assign w_commit    = (w_idle && req_valid && !w_req_err && NO_WAIT)
                       || (r_state == BUSY && r_cnt == 4'd0);
    assign w_io_hit    = (w_addr[31:2] == IO_ADDR[31:2]);
    assign w_be        = store_be(w_off, w_width);
    assign w_lanes     = w_wdata << {w_off, 3'b000};
    assign w_mem_we    = w_commit && w_we && !w_io_hit;
    assign w_load_word = w_io_hit ? ioin : w_mem_rdata;

    mem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_mem (
        .clk         (clk),
        .i_we        (w_mem_we),
        .i_be        (w_be),
        .i_word_addr (w_addr[ADDR_WIDTH-1:2]),
        .i_wdata     (w_lanes),
        .o_rdata     (w_mem_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_we         <= 1'b0;
            r_width      <= 3'd0;
            r_rdata      <= 32'd0;
            r_err        <= 1'b0;
            r_ioout      <= 32'd0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_we        <= req_we;
                        r_width     <= req_width;
                        r_req_ready <= 1'b0;
                        if (w_req_err) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_rdata      <= 32'd0;
                            r_err        <= 1'b1;
                        end else if (NO_WAIT) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                        end else begin
                            r_state <= BUSY;
                            r_cnt   <= WAIT_LOAD;
                        end
                    end
                end
                BUSY: begin
                    if (r_cnt == 4'd0) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        r_state      <= IDLE;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_commit) begin
                r_err   <= 1'b0;
                r_rdata <= w_we ? 32'd0 : load_extend(w_load_word, w_off, w_width);
                if (w_we && w_io_hit) begin
                    for (int i = 0; i < 4; i++) begin
                        if (w_be[i]) r_ioout[8*i +: 8] <= w_lanes[8*i +: 8];
                    end
                end
            end
        end
    end

    assign req_ready   = r_req_ready;
    assign resp_valid  = r_resp_valid;
    assign resp_rdata  = r_rdata;
    assign resp_err    = r_err;
    assign ioout       = r_ioout;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: byte/half/word loads and stores, errors,
// IO mapping, address wrap, response backpressure and reset during BUSY.
module tb_mem_responder;
  import mem_pkg::*;

  localparam int          WAIT = 2;
  localparam logic [31:0] IO_A = 32'h0001_FFFC;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata, ioin, resp_rdata, ioout;
  logic [2:0]  req_width;
  logic        resp_valid, resp_ready, resp_err;
  state_t      dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  mem_responder #(.ADDR_WIDTH(17), .WAIT_CYCLES(WAIT), .IO_ADDR(IO_A)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_we(req_we), .req_width(req_width),
    .ioin(ioin), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .ioout(ioout),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver: one full transaction, optionally stalling the response
  task automatic do_req(input string tag, input logic we, input logic [2:0] width,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int hold_cycles);
    int edges;
    logic [31:0] exp_d;
    exp_q.push_back(exp_rdata);
    resp_ready = (hold_cycles == 0);
    @(negedge clk);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_width = width;
    req_addr = addr;  req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom;
    req_we = 1'($urandom_range(0, 1)); req_width = 3'($urandom_range(0, 7));
    edges = 1;
    while (!resp_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, "_lat"}, 32'(edges), exp_err ? 32'd1 : 32'(WAIT + 1));
    exp_d = exp_q.pop_front();
    check({tag, "_rdata"}, resp_rdata, exp_d);
    check({tag, "_err"}, 32'(resp_err), 32'(exp_err));
    for (int i = 0; i < hold_cycles; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
      check({tag, "_hold_rdata"}, resp_rdata, exp_d);
      check({tag, "_hold_rdy"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_done"}, {30'd0, resp_valid, req_ready}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_rdata"}, resp_rdata, 32'd0);
    check({tag, "_err"}, 32'(resp_err), 32'd0);
    check({tag, "_ioout"}, ioout, 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_width = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; ioin = 32'd0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;

    do_req("sw_100",  1'b1, W_W,  32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    do_req("lw_100",  1'b0, W_W,  32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    do_req("lb_103",  1'b0, W_B,  32'h103, 32'h0, 32'hFFFFFFDE, 1'b0, 0);
    do_req("lbu_103", 1'b0, W_BU, 32'h103, 32'h0, 32'h000000DE, 1'b0, 0);
    do_req("lh_100",  1'b0, W_H,  32'h100, 32'h0, 32'hFFFFBEEF, 1'b0, 0);
    do_req("lhu_102", 1'b0, W_HU, 32'h102, 32'h0, 32'h0000DEAD, 1'b0, 0);
    do_req("sb_101",  1'b1, W_B,  32'h101, 32'h55, 32'h0, 1'b0, 0);
    do_req("lw_sb",   1'b0, W_W,  32'h100, 32'h0, 32'hDEAD55EF, 1'b0, 0);
    do_req("sh_102",  1'b1, W_H,  32'h102, 32'h1234, 32'h0, 1'b0, 0);
    do_req("lw_sh",   1'b0, W_W,  32'h100, 32'h0, 32'h123455EF, 1'b0, 0);

    do_req("err_lw",   1'b0, W_W,  32'h102, 32'h0, 32'h0, 1'b1, 0);
    do_req("err_lh",   1'b0, W_H,  32'h101, 32'h0, 32'h0, 1'b1, 0);
    do_req("err_w011", 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 0);
    do_req("err_sbu",  1'b1, W_BU, 32'h100, 32'hFF, 32'h0, 1'b1, 0);
    do_req("err_sw",   1'b1, W_W,  32'h101, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
    do_req("lw_after_err", 1'b0, W_W, 32'h100, 32'h0, 32'h123455EF, 1'b0, 0);

    ioin = 32'hA5A5_0001;
    do_req("io_lw",  1'b0, W_W, IO_A, 32'h0, 32'hA5A50001, 1'b0, 0);
    do_req("io_lh2", 1'b0, W_H, IO_A + 32'd2, 32'h0, 32'hFFFFA5A5, 1'b0, 0);
    do_req("io_lbu", 1'b0, W_BU, IO_A, 32'h0, 32'h00000001, 1'b0, 0);
    do_req("sw_alias_1fffc", 1'b1, W_W, 32'h0003_FFFC, 32'h11112222, 32'h0, 1'b0, 0);
    do_req("io_sw",  1'b1, W_W, IO_A, 32'h77, 32'h0, 1'b0, 0);
    check("ioout", ioout, 32'h77);
    do_req("storage_1fffc", 1'b0, W_W, 32'h0003_FFFC, 32'h0, 32'h11112222, 1'b0, 0);
    do_req("wrap_20100", 1'b0, W_W, 32'h0002_0100, 32'h0, 32'h123455EF, 1'b0, 0);
    do_req("wrap_hi",    1'b0, W_W, 32'h8002_0100, 32'h0, 32'h123455EF, 1'b0, 0);

    do_req("hold", 1'b0, W_W, 32'h100, 32'h0, 32'h123455EF, 1'b0, 5);

    do_req("sw_200", 1'b1, W_W, 32'h200, 32'hCAFEF00D, 32'h0, 1'b0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_width = W_W;
    req_addr = 32'h200; req_wdata = 32'h1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("busy_before_rst", 32'(dbg_state), 32'(BUSY));
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_busy");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_hold");
    rst = 1'b1;
    do_req("lw_200", 1'b0, W_W, 32'h200, 32'h0, 32'hCAFEF00D, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
